// File: rtl/rat_event_port.sv
// Button event FIFO on a CPU I/O port: synchronised button edges are queued as
// press/release bytes for the CPU. Optional per-event timestamps: RAT_EVT_TIMESTAMP_EN.
module rat_event_port #(
  parameter logic [7:0] DATA_ID   = 8'hA0,
  parameter logic [7:0] STATUS_ID = 8'hA1,
  parameter logic [7:0] CTRL_ID   = 8'hA2,
  parameter logic [7:0] TS_ID     = 8'hA3,
  parameter int         DEPTH     = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] BTN,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  input  logic [7:0] OUT_PORT,
  output logic [7:0] IN_DATA,
  output logic       IN_HIT,
  output logic       INTERRUPT
);
  localparam int AW = $clog2(DEPTH);

  logic [3:0]    r_sync1, r_sync2, r_prev, r_pend, r_pol;
  logic [1:0]    r_arm;
  logic [AW-1:0] r_wr, r_rd;
  logic [4:0]    r_count;
  logic          r_ovf, r_ie, r_int;
  logic [7:0]    r_mem [DEPTH];

  logic [3:0] w_edge, w_pend_nxt;
  logic [1:0] w_sel;
  logic       w_ctrl_wr, w_flush, w_empty, w_full, w_push_req, w_pop, w_push, w_drop;
  logic [7:0] w_head, w_status;
  logic       w_unused;

  // Edge detection stays off until the synchronizer and previous-value copy hold real samples.
  // NOTE: non-blocking assignments so every flop samples the values from before the edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_arm   <= '0;
      r_pend  <= '0;
      r_pol   <= '0;
    end else begin
      r_sync1 <= BTN;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
      r_pend  <= w_pend_nxt;
      r_pol   <= (r_pol & ~w_edge) | (r_sync2 & w_edge);
    end
  end

  assign w_edge     = (r_arm == 2'd3) ? (r_sync2 ^ r_prev) : 4'd0;
  assign w_ctrl_wr  = IO_STRB && (PORT_ID == CTRL_ID);
  assign w_flush    = w_ctrl_wr && OUT_PORT[2];
  assign w_empty    = (r_count == 5'd0);
  assign w_full     = (r_count == 5'(DEPTH));
  assign w_push_req = |r_pend;
  assign w_pop      = w_ctrl_wr && OUT_PORT[0] && !w_empty && !w_flush;
  assign w_push     = w_push_req && !w_flush && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_flush && w_full && !w_pop;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pend[i]) w_sel = 2'(i);
    end
  end

  // A new edge on the button being serviced wins over clearing its flag.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_push_req) w_pend_nxt[w_sel] = 1'b0;
    w_pend_nxt = w_pend_nxt | w_edge;
    if (w_flush) w_pend_nxt = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_ie    <= 1'b0;
      r_int   <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_pop)  r_rd <= r_rd + 1'b1;
        r_count <= r_count + 5'(w_push) - 5'(w_pop);
      end
      if (w_drop) r_ovf <= 1'b1;
      else if (w_ctrl_wr && OUT_PORT[1]) r_ovf <= 1'b0;
      if (w_ctrl_wr) r_ie <= OUT_PORT[7];
      r_int <= r_ie && !w_empty;
    end
  end

  // NOTE: storage has no reset; entries are only visible through the reset pointers and count.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= {r_pol[w_sel], 5'b0, w_sel};
  end

`ifdef RAT_EVT_TIMESTAMP_EN
  logic [15:0] r_pre;
  logic [7:0]  r_ts;
  logic [7:0]  r_ts_mem [DEPTH];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pre <= '0;
      r_ts  <= '0;
    end else begin
      r_pre <= r_pre + 16'd1;
      if (&r_pre) r_ts <= r_ts + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_ts_mem[r_wr] <= r_ts;
  end

  assign w_unused = ^OUT_PORT[6:3];
`else
  assign w_unused = ^{OUT_PORT[6:3], TS_ID};
`endif

  assign w_head   = w_empty ? 8'h00 : r_mem[r_rd];
  assign w_status = {r_count[3:0], r_ovf, r_ie, w_full, w_empty};

  always_comb begin
    IN_DATA = 8'h00;
    IN_HIT  = 1'b0;
    if (PORT_ID == DATA_ID) begin
      IN_DATA = w_head;
      IN_HIT  = 1'b1;
    end else if (PORT_ID == STATUS_ID) begin
      IN_DATA = w_status;
      IN_HIT  = 1'b1;
    end
`ifdef RAT_EVT_TIMESTAMP_EN
    else if (PORT_ID == TS_ID) begin
      IN_DATA = w_empty ? 8'h00 : r_ts_mem[r_rd];
      IN_HIT  = 1'b1;
    end
`endif
  end

  assign INTERRUPT = r_int;

endmodule
